// File: rtl/seg7_seq_monitor.sv
// Two-digit seven-segment sequence monitor.
// Debounces the displayed pair, decodes it to 0..15 and checks that successive
// accepted values step by one in the direction given by up. Errors are counted
// and latch the FSM into a fault state until clear.
module seg7_seq_monitor #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] decsegm,
  input  logic [6:0] unisegm,
  input  logic       up,
  input  logic       clear,
  output logic [3:0] value,
  output logic       accept,
  output logic       err_pattern,
  output logic       err_step,
  output logic       fault,
  output logic [7:0] step_count,
  output logic [7:0] err_count
);

  localparam logic [3:0] StableMax = 4'(STABLE_CYCLES);
  // Blank display: all segments off (active-low).
  localparam logic [13:0] PairBlank = 14'h3fff;

  typedef enum logic [1:0] {
    StSync,
    StTrack,
    StFault
  } state_e;

  state_e      state_q;
  logic [6:0]  dec_q;
  logic [6:0]  uni_q;
  logic [3:0]  cnt_q;
  logic [3:0]  cnt_d;
  logic [13:0] pair_in;
  logic [13:0] pair_q;
  logic [13:0] last_q;

  logic        accept_evt;
  logic [4:0]  dec_tens;
  logic [4:0]  dec_units;
  logic [4:0]  pair_sum;
  logic        pair_legal;
  logic [3:0]  pair_val;
  logic [3:0]  expected;
  logic        step_ok;
  logic [7:0]  step_count_inc;
  logic [7:0]  err_count_inc;

  // Returns {valid, digit[3:0]} for one active-low {g,f,e,d,c,b,a} pattern.
  function automatic logic [4:0] seg_decode(input logic [6:0] seg);
    logic [4:0] res;
    case (seg)
      7'b1000000: res = {1'b1, 4'd0};
      7'b1111001: res = {1'b1, 4'd1};
      7'b0100100: res = {1'b1, 4'd2};
      7'b0110000: res = {1'b1, 4'd3};
      7'b0011001: res = {1'b1, 4'd4};
      7'b0010010: res = {1'b1, 4'd5};
      7'b0000010: res = {1'b1, 4'd6};
      7'b1111000: res = {1'b1, 4'd7};
      7'b0000000: res = {1'b1, 4'd8};
      7'b0010000: res = {1'b1, 4'd9};
      default:    res = {1'b0, 4'd0};
    endcase
    return res;
  endfunction

  assign pair_in = {decsegm, unisegm};
  assign pair_q  = {dec_q, uni_q};

  // Stability counter next state: restart whenever the newly registered pair differs.
  always_comb begin
    cnt_d = cnt_q;
    if (pair_in != pair_q) begin
      cnt_d = 4'd0;
    end else if (cnt_q != StableMax) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  // A pair is taken once it has been stable long enough and is not the one already taken.
  assign accept_evt = (cnt_d == StableMax) && (pair_q != last_q);

  // Decode the held pair and form the expected next value of the sequence.
  always_comb begin
    dec_tens   = seg_decode(dec_q);
    dec_units  = seg_decode(uni_q);
    pair_sum   = (dec_tens[0] ? 5'd10 : 5'd0) + {1'b0, dec_units[3:0]};
    pair_legal = dec_tens[4] && dec_units[4] && (dec_tens[3:0] <= 4'd1) && (pair_sum <= 5'd15);
    pair_val   = pair_sum[3:0];
    // 4-bit arithmetic gives the 15->0 and 0->15 wrap for free.
    expected   = up ? (value + 4'd1) : (value - 4'd1);
    step_ok    = (pair_val == expected);
  end

  // Saturating increments for the two event counters.
  always_comb begin
    step_count_inc = (step_count == 8'hff) ? step_count : step_count + 8'd1;
    err_count_inc  = (err_count == 8'hff) ? err_count : err_count + 8'd1;
  end

  // Input registers and stability counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dec_q <= 7'h7f;
      uni_q <= 7'h7f;
      cnt_q <= 4'd0;
    end else begin
      dec_q <= decsegm;
      uni_q <= unisegm;
      cnt_q <= cnt_d;
    end
  end

  // Sequence-check FSM with registered pulses, counters and value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StSync;
      value       <= 4'd0;
      accept      <= 1'b0;
      err_pattern <= 1'b0;
      err_step    <= 1'b0;
      fault       <= 1'b0;
      step_count  <= 8'd0;
      err_count   <= 8'd0;
      last_q      <= PairBlank;
    end else begin
      accept      <= 1'b0;
      err_pattern <= 1'b0;
      err_step    <= 1'b0;
      if (clear) begin
        // Clear wins over a same-edge acceptance; value is deliberately kept.
        state_q    <= StSync;
        fault      <= 1'b0;
        step_count <= 8'd0;
        err_count  <= 8'd0;
        last_q     <= '0;
      end else if (accept_evt) begin
        // Remember even illegal pairs so a held bad pattern is flagged only once.
        last_q <= pair_q;
        if (!pair_legal) begin
          err_pattern <= 1'b1;
          err_count   <= err_count_inc;
          state_q     <= StFault;
          fault       <= 1'b1;
        end else begin
          value  <= pair_val;
          accept <= 1'b1;
          case (state_q)
            StSync: begin
              state_q <= StTrack;
            end
            StTrack: begin
              if (step_ok) begin
                step_count <= step_count_inc;
              end else begin
                err_step  <= 1'b1;
                err_count <= err_count_inc;
                state_q   <= StFault;
                fault     <= 1'b1;
              end
            end
            StFault: begin
              if (!step_ok) begin
                err_step  <= 1'b1;
                err_count <= err_count_inc;
              end
            end
            default: begin
              state_q <= StSync;
              fault   <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_seq_monitor.sv
// Randomised and directed bench for seg7_seq_monitor against a behavioural model.
module tb_seg7_seq_monitor;

  localparam int S = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] decsegm;
  logic [6:0] unisegm;
  logic       up;
  logic       clear;
  logic [3:0] value;
  logic       accept;
  logic       err_pattern;
  logic       err_step;
  logic       fault;
  logic [7:0] step_count;
  logic [7:0] err_count;

  seg7_seq_monitor #(.STABLE_CYCLES(S)) dut (
    .clk        (clk),
    .rst        (rst),
    .decsegm    (decsegm),
    .unisegm    (unisegm),
    .up         (up),
    .clear      (clear),
    .value      (value),
    .accept     (accept),
    .err_pattern(err_pattern),
    .err_step   (err_step),
    .fault      (fault),
    .step_count (step_count),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  int n_checks = 0;
  int n_errors = 0;
  int n_acc = 0;
  int n_ep = 0;
  int n_es = 0;

  // Reference model state: state 0=sync, 1=track, 2=fault.
  logic [13:0] hist[$];
  logic [13:0] m_last;
  int          m_state;
  int          m_value;
  int          m_acc, m_ep, m_es;
  int          m_sc, m_ec;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int seg_digit(input logic [6:0] s);
    for (int i = 0; i < 10; i++) if (seg_tab[i] == s) return i;
    return -1;
  endfunction

  task automatic model_reset();
    hist.delete();
    hist.push_back(14'h3fff);
    m_last  = 14'h3fff;
    m_state = 0;
    m_value = 0;
    m_acc = 0; m_ep = 0; m_es = 0;
    m_sc = 0; m_ec = 0;
  endtask

  task automatic model_edge();
    logic [13:0] pair;
    bit          stable;
    int          t, u, v, expv;
    pair = {decsegm, unisegm};
    hist.push_back(pair);
    while (hist.size() > S + 1) void'(hist.pop_front());
    // Taken once the same pair has been seen S+1 samples in a row.
    stable = (hist.size() == S + 1);
    foreach (hist[i]) if (hist[i] != pair) stable = 0;
    m_acc = 0; m_ep = 0; m_es = 0;
    if (clear) begin
      m_state = 0; m_sc = 0; m_ec = 0; m_last = '0;
    end else if (stable && pair != m_last) begin
      m_last = pair;
      t = seg_digit(decsegm);
      u = seg_digit(unisegm);
      if (t < 0 || u < 0 || t > 1 || 10 * t + u > 15) begin
        m_ep = 1;
        m_ec = (m_ec < 255) ? m_ec + 1 : 255;
        m_state = 2;
      end else begin
        v = 10 * t + u;
        m_acc = 1;
        expv = up ? (m_value + 1) % 16 : (m_value + 15) % 16;
        if (m_state == 0) m_state = 1;
        else if (v == expv) begin
          if (m_state == 1) m_sc = (m_sc < 255) ? m_sc + 1 : 255;
        end else begin
          m_es = 1;
          m_ec = (m_ec < 255) ? m_ec + 1 : 255;
          m_state = 2;
        end
        m_value = v;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".value"}, 32'(value), 32'(m_value));
    check({tag, ".accept"}, 32'(accept), 32'(m_acc));
    check({tag, ".err_pattern"}, 32'(err_pattern), 32'(m_ep));
    check({tag, ".err_step"}, 32'(err_step), 32'(m_es));
    check({tag, ".fault"}, 32'(fault), 32'(m_state == 2));
    check({tag, ".step_count"}, 32'(step_count), 32'(m_sc));
    check({tag, ".err_count"}, 32'(err_count), 32'(m_ec));
  endtask

  // One clock: advance the model, then compare just after the edge.
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
    n_acc += int'(accept);
    n_ep  += int'(err_pattern);
    n_es  += int'(err_step);
  endtask

  task automatic hold(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  task automatic set_val(input int v);
    decsegm = seg_tab[v / 10];
    unisegm = seg_tab[v % 10];
  endtask

  task automatic clr_counts();
    n_acc = 0; n_ep = 0; n_es = 0;
  endtask

  int lat;
  int kind;
  int nv;

  initial begin
    rst = 1'b1; clear = 1'b0; up = 1'b1;
    decsegm = 7'h7f; unisegm = 7'h7f;
    model_reset();
    #12;
    check_all("reset");
    rst = 1'b0;

    // "03" after reset: accepted five clocks after the change, no step check.
    set_val(3);
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      step("first");
      if (accept && lat == 0) lat = i;
    end
    check("first.latency", 32'(lat), 32'd5);
    check("first.value", 32'(value), 32'd3);
    check("first.step_count", 32'(step_count), 32'd0);

    // Count up 4..15 then wrap to 0.
    clr_counts();
    up = 1'b1;
    for (int v = 4; v <= 16; v++) begin
      set_val(v % 16);
      hold("up", 8);
    end
    check("up.accepts", 32'(n_acc), 32'd13);
    check("up.step_count", 32'(step_count), 32'd13);
    check("up.errors", 32'(n_ep + n_es), 32'd0);
    check("up.fault", 32'(fault), 32'd0);

    // Down from 0 wraps to 15, then 13 is a bad step.
    clr_counts();
    up = 1'b0;
    set_val(15);
    hold("down", 8);
    check("down.wrap_value", 32'(value), 32'd15);
    check("down.wrap_fault", 32'(fault), 32'd0);
    set_val(13);
    hold("down", 8);
    check("down.err_step", 32'(n_es), 32'd1);
    check("down.err_count", 32'(err_count), 32'd1);
    check("down.fault", 32'(fault), 32'd1);

    // Two-clock glitch to "09" is ignored.
    clr_counts();
    set_val(9);
    hold("glitch", 2);
    set_val(13);
    hold("glitch", 8);
    check("glitch.accepts", 32'(n_acc), 32'd0);
    check("glitch.value", 32'(value), 32'd13);

    // "17" is illegal: flagged once, value held; clear restores SYNC.
    clr_counts();
    set_val(17);
    hold("illegal", 10);
    check("illegal.err_pattern", 32'(n_ep), 32'd1);
    check("illegal.value", 32'(value), 32'd13);
    check("illegal.fault", 32'(fault), 32'd1);
    clear = 1'b1;
    step("clear");
    clear = 1'b0;
    check("clear.fault", 32'(fault), 32'd0);
    check("clear.step_count", 32'(step_count), 32'd0);
    check("clear.err_count", 32'(err_count), 32'd0);
    set_val(5);
    hold("resync", 8);
    check("resync.value", 32'(value), 32'd5);

    // Enter FAULT, then assert reset between edges.
    up = 1'b1;
    set_val(7);
    hold("prefault", 8);
    check("prefault.fault", 32'(fault), 32'd1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("arst.value", 32'(value), 32'd0);
    check("arst.fault", 32'(fault), 32'd0);
    check("arst.err_count", 32'(err_count), 32'd0);
    check_all("arst");
    #1 rst = 1'b0;
    clr_counts();
    hold("postrst", 8);
    check("postrst.accepts", 32'(n_acc), 32'd1);
    check("postrst.value", 32'(value), 32'd7);
    check("postrst.fault", 32'(fault), 32'd0);

    // Randomised mix of steps, bad steps, glitches, illegal patterns and clears.
    for (int k = 0; k < 400; k++) begin
      kind = int'($urandom_range(0, 19));
      up = 1'($urandom_range(0, 1));
      if (kind == 0) begin
        decsegm = 7'($urandom);
        unisegm = 7'($urandom);
        hold("rnd_raw", int'($urandom_range(1, S + 3)));
      end else if (kind == 1) begin
        clear = 1'b1;
        step("rnd_clear");
        clear = 1'b0;
      end else if (kind == 2) begin
        set_val(int'($urandom_range(0, 15)));
        hold("rnd_glitch", int'($urandom_range(1, S)));
      end else if (kind == 3) begin
        set_val(int'($urandom_range(10, 19)));
        hold("rnd_big", int'($urandom_range(S, S + 3)));
      end else if (kind < 7) begin
        set_val(int'($urandom_range(0, 15)));
        hold("rnd_any", int'($urandom_range(S, S + 4)));
      end else begin
        nv = up ? (m_value + 1) % 16 : (m_value + 15) % 16;
        set_val(nv);
        hold("rnd_step", int'($urandom_range(S + 1, S + 4)));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/seg7_seq_monitor.md
SEG7_SEQ_MONITOR -- requirements
Module: seg7_seq_monitor

Interface
REQ-001 The module SHALL have parameter STABLE_CYCLES, default 4, the number of consecutive clock edges a segment pattern must hold before it is accepted (legal range 2..15).
REQ-002 The module SHALL have port clk, input, 1 bit: single system clock; all state SHALL change on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The module SHALL have port decsegm, input, 7 bits: tens-digit segments, order {g,f,e,d,c,b,a}, active-low.
REQ-005 The module SHALL have port unisegm, input, 7 bits: units-digit segments, same order and polarity as decsegm.
REQ-006 The module SHALL have port up, input, 1 bit: expected count direction, 1 = up, 0 = down.
REQ-007 The module SHALL have port clear, input, 1 bit: synchronous fault and counter clear.
REQ-008 The module SHALL have port value, output, 4 bits: last accepted decoded count.
REQ-009 The module SHALL have port accept, output, 1 bit: one-cycle pulse when a new pattern is accepted.
REQ-010 The module SHALL have port err_pattern, output, 1 bit: one-cycle pulse when a stable illegal pattern is accepted.
REQ-011 The module SHALL have port err_step, output, 1 bit: one-cycle pulse when an accepted value is an illegal step.
REQ-012 The module SHALL have port fault, output, 1 bit: sticky error flag.
REQ-013 The module SHALL have port step_count, output, 8 bits: legal steps seen, saturating at 255.
REQ-014 The module SHALL have port err_count, output, 8 bits: errors seen, saturating at 255.

Function
REQ-015 Digit patterns SHALL be decoded as follows: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000; any other pattern is illegal.
REQ-016 A pair SHALL be legal only if the tens digit is 0 or 1, the units digit is legal, and the decoded value 10*tens+units is at most 15.
REQ-017 Both segment inputs SHALL be registered once; a stability counter SHALL reset to 0 when the registered pair differs from its previous registered value, and otherwise increment, saturating at STABLE_CYCLES.
REQ-018 Acceptance SHALL occur on the edge where the stability counter reaches STABLE_CYCLES and the registered pair differs from the last accepted pair, giving latency of STABLE_CYCLES+1 clocks from an input change to accept.
REQ-019 A pattern that changes before reaching stability SHALL be ignored, with no pulse and no update.
REQ-020 The FSM SHALL have three states: SYNC, TRACK and FAULT.
REQ-021 In SYNC, a legal acceptance SHALL load value, pulse accept and go to TRACK, with no step check.
REQ-022 In TRACK, a legal acceptance SHALL compute the expected value as (last+1) mod 16 if up=1, or (last-1) mod 16 if up=0, using up as sampled on the accept edge.
REQ-023 A match with the expected value SHALL increment step_count; a mismatch SHALL pulse err_step, increment err_count and go to FAULT.
REQ-024 Wrap-around SHALL be legal: 15 to 0 when up=1, and 0 to 15 when up=0.
REQ-025 In any state, an illegal acceptance SHALL pulse err_pattern, increment err_count, hold value and go to FAULT; the last accepted pair SHALL still update so that the same illegal pattern is not counted again.
REQ-026 In FAULT, legal acceptances SHALL still update value and pulse accept; step checks SHALL continue, with err_step and err_count active; step_count SHALL not increment.
REQ-027 fault SHALL be 1 exactly while the FSM is in FAULT.
REQ-028 When clear=1, the module SHALL go to SYNC and zero step_count, err_count and the last accepted pair (so the next stable pattern is accepted); clear SHALL win over a simultaneous acceptance, with no pulses on that edge; value SHALL be held.
REQ-029 A direction change between steps SHALL be legal; only the up level on the accept edge matters.

Reset
REQ-030 While rst=1, the module SHALL asynchronously set the FSM to SYNC, value=0, accept=err_pattern=err_step=fault=0, step_count=err_count=0, the stability counter to 0, the input registers to 1111111, and the last accepted pair to 1111111/1111111.
REQ-031 Reset asserted mid-stability or mid-FAULT SHALL discard all progress; after release, the first stable legal pair SHALL be handled as in SYNC.

Verification
REQ-032 The bench SHALL cover: after reset, apply "0","3" stable for 10 clocks -> accept pulse exactly 5 clocks after the change, value=3, state TRACK, step_count=0.
REQ-033 The bench SHALL cover: with up=1, step 3,4,...,15,0 holding each for 8 clocks -> 13 accept pulses, step_count=13, no errors, fault=0.
REQ-034 The bench SHALL cover: with up=0 from value 0, apply "1","5" -> legal wrap to 15; then apply "1","3" -> err_step pulse, err_count=1, fault=1.
REQ-035 The bench SHALL cover: a glitch that holds "0","9" for 2 clocks and then returns -> no accept, value unchanged.
REQ-036 The bench SHALL cover: a stable "1","7" (value 17) -> err_pattern pulse once, value held, fault=1; then clear=1 for one clock -> SYNC, counters 0, fault=0.
REQ-037 The bench SHALL cover: rst asserted asynchronously between clock edges while in FAULT -> all outputs 0 immediately, without waiting for a clock edge.
